// File: rtl/stat_display_sel_pkg.sv
// Shared definitions for the statistics display selector.
//   mode_e   : display mode encodings driven by the mode switches
//   CH_*     : channel index of each CPU statistic on the ch_data bus
package stat_display_sel_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_FREEZE = 2'b10,
    MODE_SNAP   = 2'b11
  } mode_e;

  localparam int unsigned CH_SYSCALL  = 0;
  localparam int unsigned CH_PC       = 1;
  localparam int unsigned CH_CYCLES   = 2;
  localparam int unsigned CH_JUMP     = 3;
  localparam int unsigned CH_BR_TAKEN = 4;
  localparam int unsigned CH_BRANCH   = 5;
  localparam int unsigned CH_MDATA    = 6;

endpackage

// File: rtl/stat_dwell_timer.sv
// Dwell counter for auto-rotate mode.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the dwell period (count <= 0)
//   hold       : freeze the count
//   tick_c     : high for the cycle in which the count reaches DWELL-1
module stat_dwell_timer #(
  parameter int unsigned DWELL = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  // Clear wins over hold; a tick restarts the period.
  assign tick_c = !clear && !hold && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= tick_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stat_display_sel.sv
// CPU statistics display selector with manual, auto-rotate, freeze and
// snapshot modes.
//   clk, reset  : clock, asynchronous active-high reset
//   ch_data     : NUM_CH flattened channels, channel k at [k*DATA_W +: DATA_W]
//   ch_sel      : manual channel select
//   mode        : 00 manual, 01 auto-rotate, 10 freeze, 11 snapshot
//   snap_req    : snapshot request level, captured on its rising edge
//   in_addr     : RAM address switches
//   chose_out   : registered display word
//   cur_ch      : registered index of the channel shown
//   snap_valid  : a snapshot has been captured since reset
//   RAM_addr    : combinational copy of in_addr
module stat_display_sel
  import stat_display_sel_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned DWELL  = 50000000,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic [1:0]               mode,
  input  logic                     snap_req,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic [DATA_W-1:0]        chose_out,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     snap_valid,
  output logic [ADDR_W-1:0]        RAM_addr
);

  mode_e                     mode_cur;
  mode_e                     prev_mode;
  logic                      snap_req_q;
  logic [NUM_CH*DATA_W-1:0]  snap;
  logic                      capture_c;
  logic                      auto_entry_c;
  logic                      tick_c;
  logic [SEL_W-1:0]          cur_ch_d;
  logic [DATA_W-1:0]         chose_d;

  // Channel lookup; any index outside the bank falls back to channel 0.
  function automatic logic [DATA_W-1:0] pick_ch(
    input logic [NUM_CH*DATA_W-1:0] flat,
    input logic [SEL_W-1:0]         idx
  );
    logic [DATA_W-1:0] sel;
    sel = flat[DATA_W-1:0];
    for (int unsigned k = 1; k < NUM_CH; k++) begin
      if (idx == SEL_W'(k)) sel = flat[k*DATA_W +: DATA_W];
    end
    return sel;
  endfunction

  assign RAM_addr     = in_addr;
  assign mode_cur     = mode_e'(mode);
  assign capture_c    = snap_req && !snap_req_q;
  assign auto_entry_c = (mode_cur == MODE_AUTO) && (prev_mode != MODE_AUTO);

  // Counter runs only while staying in auto mode; entry restarts it.
  stat_dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (auto_entry_c),
    .hold  (mode_cur != MODE_AUTO),
    .tick_c(tick_c)
  );

  // Next display word and channel index per mode.
  always_comb begin
    cur_ch_d = cur_ch;
    chose_d  = chose_out;
    unique case (mode_cur)
      MODE_MANUAL: begin
        cur_ch_d = ch_sel;
        chose_d  = pick_ch(ch_data, ch_sel);
      end
      MODE_AUTO: begin
        if (auto_entry_c) begin
          cur_ch_d = ch_sel;
        end else if (tick_c) begin
          cur_ch_d = (cur_ch >= SEL_W'(NUM_CH - 1)) ? '0 : cur_ch + SEL_W'(1);
        end
        chose_d = pick_ch(ch_data, cur_ch);
      end
      MODE_FREEZE: begin
        cur_ch_d = cur_ch;
        chose_d  = chose_out;
      end
      MODE_SNAP: begin
        cur_ch_d = ch_sel;
        // Reads the bank before this cycle's capture lands.
        chose_d  = pick_ch(snap, ch_sel);
      end
      default: begin
        cur_ch_d = cur_ch;
        chose_d  = chose_out;
      end
    endcase
  end

  // Display, snapshot bank and edge/mode history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chose_out  <= '0;
      cur_ch     <= '0;
      snap_valid <= 1'b0;
      snap_req_q <= 1'b0;
      snap       <= '0;
      prev_mode  <= MODE_MANUAL;
    end else begin
      chose_out  <= chose_d;
      cur_ch     <= cur_ch_d;
      snap_req_q <= snap_req;
      prev_mode  <= mode_cur;
      if (capture_c) begin
        snap       <= ch_data;
        snap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stat_display_sel.sv
// Self-checking bench for stat_display_sel (NUM_CH=7, DWELL=4).
module tb_stat_display_sel;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_CH = 7;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DWELL  = 4;
  localparam int unsigned ADDR_W = 12;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [SEL_W-1:0]         ch_sel;
  logic [1:0]               mode;
  logic                     snap_req;
  logic [ADDR_W-1:0]        in_addr;
  logic [DATA_W-1:0]        chose_out;
  logic [SEL_W-1:0]         cur_ch;
  logic                     snap_valid;
  logic [ADDR_W-1:0]        RAM_addr;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  ch;
    logic              valid;
  } exp_t;

  exp_t              sb[$];
  exp_t              e;
  int                checks   = 0;
  int                failures = 0;
  logic [DATA_W-1:0] chv [NUM_CH];

  stat_display_sel #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W),
    .DWELL(DWELL), .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_data   (ch_data),
    .ch_sel    (ch_sel),
    .mode      (mode),
    .snap_req  (snap_req),
    .in_addr   (in_addr),
    .chose_out (chose_out),
    .cur_ch    (cur_ch),
    .snap_valid(snap_valid),
    .RAM_addr  (RAM_addr)
  );

  always #5 clk = ~clk;

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    chv[k] = v;
    ch_data[k*DATA_W +: DATA_W] = v;
  endtask

  function automatic logic [DATA_W-1:0] ch_val(input int idx);
    return (idx >= int'(NUM_CH)) ? chv[0] : chv[idx];
  endfunction

  task automatic push_exp(input logic [DATA_W-1:0] d, input int c, input logic v);
    exp_t x;
    x.data  = d;
    x.ch    = SEL_W'(c);
    x.valid = v;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_addr = 12'hABC;
    #1;
    checks++;
    if (RAM_addr !== 12'hABC) begin
      failures++;
      $display("FAIL reset_ram_addr: got %h exp abc", RAM_addr);
    end
    tick();
    tick();
    checks++;
    if ({chose_out, cur_ch, snap_valid} !== {32'h0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got data=%h ch=%0d valid=%b exp 0/0/0",
               chose_out, cur_ch, snap_valid);
    end
    in_addr = 12'h123;
    #1;
    checks++;
    if (RAM_addr !== 12'h123) begin
      failures++;
      $display("FAIL reset_ram_addr2: got %h exp 123", RAM_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_manual();
    mode   = 2'b00;
    ch_sel = 3'd1;
    push_exp(32'h00400020, 1, 1'b0);
    tick();
    e = sb.pop_front();
    checks++;
    if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
      failures++;
      $display("FAIL manual_ch1: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
               chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
    end
    for (int s = 0; s < 8; s++) begin
      ch_sel = SEL_W'(s);
      push_exp(ch_val(s), s, 1'b0);
      tick();
      e = sb.pop_front();
      checks++;
      if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
        failures++;
        $display("FAIL manual_sel%0d: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
                 s, chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
      end
    end
  endtask

  // Entry from manual with cur_ch=7: first word is the out-of-range fallback.
  task automatic test_auto();
    int prev;
    int ex;
    prev   = 7;
    mode   = 2'b01;
    ch_sel = 3'd5;
    for (int i = 0; i < 12; i++) begin
      ex = (i < 4) ? 5 : (i < 8) ? 6 : 0;
      push_exp(ch_val(prev), ex, 1'b0);
      prev = ex;
      tick();
      e = sb.pop_front();
      checks++;
      if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
        failures++;
        $display("FAIL auto_step%0d: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
                 i, chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
      end
    end
  endtask

  task automatic test_freeze();
    mode   = 2'b00;
    ch_sel = 3'd2;
    set_ch(2, 32'h1234);
    push_exp(32'h1234, 2, 1'b0);
    for (int i = 0; i < 22; i++) begin
      if (i == 1) begin
        mode   = 2'b10;
        ch_sel = 3'd5;
        set_ch(2, 32'h9999);
      end
      if (i > 0) push_exp(32'h1234, 2, 1'b0);
      // Leaving freeze into auto reloads cur_ch from ch_sel.
      if (i == 21) begin
        void'(sb.pop_back());
        mode   = 2'b01;
        ch_sel = 3'd4;
        push_exp(32'h9999, 4, 1'b0);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
        failures++;
        $display("FAIL freeze_step%0d: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
                 i, chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
      end
    end
  endtask

  task automatic test_snapshot();
    mode   = 2'b00;
    ch_sel = 3'd3;
    for (int i = 0; i < 5; i++) begin
      snap_req = 1'b1;
      set_ch(3, DATA_W'(10 + i));
      push_exp(DATA_W'(10 + i), 3, 1'b1);
      tick();
      e = sb.pop_front();
      checks++;
      if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
        failures++;
        $display("FAIL snap_hold%0d: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
                 i, chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
      end
    end
    snap_req = 1'b0;
    mode     = 2'b11;
    for (int i = 0; i < 6; i++) begin
      set_ch(3, DATA_W'(15 + i));
      ch_sel = (i == 4) ? 3'd1 : (i == 5) ? 3'd2 : 3'd3;
      push_exp((i == 4) ? 32'h00400020 : (i == 5) ? 32'h9999 : 32'd10,
               int'(ch_sel), 1'b1);
      tick();
      e = sb.pop_front();
      checks++;
      if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
        failures++;
        $display("FAIL snap_read%0d: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
                 i, chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
      end
    end
    // Capture and read in the same cycle: old snapshot first, new one next.
    ch_sel   = 3'd3;
    set_ch(3, 32'd77);
    snap_req = 1'b1;
    push_exp(32'd10, 3, 1'b1);
    push_exp(32'd77, 3, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
        failures++;
        $display("FAIL snap_same_cycle%0d: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
                 i, chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    mode   = 2'b01;
    ch_sel = 3'd2;
    push_exp(32'd77, 2, 1'b1);
    push_exp(32'h9999, 2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
        failures++;
        $display("FAIL pre_reset%0d: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
                 i, chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
      end
    end
    reset   = 1'b1;
    in_addr = 12'hABC;
    #1;
    checks++;
    if ({chose_out, cur_ch, snap_valid, RAM_addr} !== {32'h0, 3'd0, 1'b0, 12'hABC}) begin
      failures++;
      $display("FAIL async_reset: got data=%h ch=%0d valid=%b addr=%h exp 0/0/0/abc",
               chose_out, cur_ch, snap_valid, RAM_addr);
    end
    #2;
    reset    = 1'b0;
    snap_req = 1'b0;
    mode     = 2'b11;
    for (int i = 0; i < 2; i++) begin
      ch_sel = (i == 0) ? 3'd3 : 3'd6;
      push_exp(32'h0, int'(ch_sel), 1'b0);
      tick();
      e = sb.pop_front();
      checks++;
      if ({chose_out, cur_ch, snap_valid} !== {e.data, e.ch, e.valid}) begin
        failures++;
        $display("FAIL post_reset_snap%0d: got data=%h ch=%0d valid=%b exp data=%h ch=%0d valid=%b",
                 i, chose_out, cur_ch, snap_valid, e.data, e.ch, e.valid);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    ch_data  = '0;
    ch_sel   = '0;
    mode     = 2'b00;
    snap_req = 1'b0;
    in_addr  = '0;
    for (int k = 0; k < int'(NUM_CH); k++) set_ch(k, 32'hC0DE_0000 + DATA_W'(k * 17));
    set_ch(1, 32'h00400020);

    test_reset();
    test_manual();
    test_auto();
    test_freeze();
    test_snapshot();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
